pipe_ctrl: RTL

Pipelined control unit for the five-stage MIPS core; generalised successor to the single-cycle combinational decoder. Decodes the instruction in ID, carries the control bundle through the ID/EX, EX/MEM and MEM/WB control registers, and generates load-use/jump-register stalls and branch/jump flushes. An optional multi-cycle multiply/divide interlock is built in with a compile-time macro.

---
 rtl/pipe_ctrl_pkg.sv | 62 ++++++
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl_ctrl_decode.sv | 88 ++++++++
 rtl/pipe_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode/funct constants, control encodings and bundle types for pipe_ctrl.
// Muldiv bundle fields exist only when PIPE_CTRL_MULDIV_EN is defined.
package pipe_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
   localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
   localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08, F_JALR = 6'h09;
   localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_BEQ = 3'b001, ALU_R = 3'b010, ALU_AND = 3'b100, ALU_SLT = 3'b101;
   typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_31 = 2'b10} regdst_e;
   typedef enum logic [1:0] {MR_ALU = 2'b00, MR_MEM = 2'b01, MR_PC4 = 2'b10} memtoreg_e;
   typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_J = 2'b01, PC_JR = 2'b10} pcsrc_e;
   typedef struct packed {
      logic       valid;
      logic       uses_rt;
      logic       alusrc1;
      logic       alusrc2;
      logic       branch;
      logic [3:0] aluop;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       luop;
      memtoreg_e  memtoreg;
      pcsrc_e     pcsrc;
`ifdef PIPE_CTRL_MULDIV_EN
      logic       muldiv;
      logic       mfhilo;
`endif
   } ctrl_t;
   typedef struct packed {
      logic       valid;
      logic       alusrc1;
      logic       alusrc2;
      logic       branch;
      logic [3:0] aluop;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      memtoreg_e  memtoreg;
`ifdef PIPE_CTRL_MULDIV_EN
      logic       muldiv;
`endif
   } ex_t;
   typedef struct packed {
      logic      memread;
      logic      memwrite;
      logic      regwrite;
      memtoreg_e memtoreg;
   } mem_t;
   typedef struct packed {
      logic      regwrite;
      memtoreg_e memtoreg;
   } wb_t;
   function automatic logic is_muldiv(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction
   function automatic logic is_shift(input logic [5:0] f);
      return f == F_SLL || f == F_SRL || f == F_SRA;
   endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage inputs and pipelined control outputs of pipe_ctrl.
// master drives the ID fields (datapath side); slave is the control unit.
interface pipe_ctrl_if #(parameter int REG_AW = 5);
   logic              id_valid;
   logic [5:0]        id_opcode, id_funct;
   logic [REG_AW-1:0] id_rs, id_rt, id_rd;
   logic              branch_taken_ex;
   logic              pc_write, ifid_write, flush_ifid;
   logic [1:0]        id_pcsrc;
   logic              id_extop, id_luop;
   logic              ex_valid, ex_alusrc1, ex_alusrc2, ex_branch;
   logic [3:0]        ex_aluop;
   logic              ex_memread, ex_memwrite, ex_regwrite;
   logic [REG_AW-1:0] ex_wdst;
   logic              mem_memread, mem_memwrite, mem_regwrite;
   logic [1:0]        mem_memtoreg;
   logic [REG_AW-1:0] mem_wdst;
   logic              wb_regwrite;
   logic [1:0]        wb_memtoreg;
   logic [REG_AW-1:0] wb_wdst;
   logic              muldiv_start, muldiv_busy;
   modport master (
      output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, branch_taken_ex,
      input  pc_write, ifid_write, flush_ifid, id_pcsrc, id_extop, id_luop,
      input  ex_valid, ex_alusrc1, ex_alusrc2, ex_branch, ex_aluop, ex_memread, ex_memwrite, ex_regwrite, ex_wdst,
      input  mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_wdst,
      input  wb_regwrite, wb_memtoreg, wb_wdst, muldiv_start, muldiv_busy
   );
   modport slave (
      input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, branch_taken_ex,
      output pc_write, ifid_write, flush_ifid, id_pcsrc, id_extop, id_luop,
      output ex_valid, ex_alusrc1, ex_alusrc2, ex_branch, ex_aluop, ex_memread, ex_memwrite, ex_regwrite, ex_wdst,
      output mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_wdst,
      output wb_regwrite, wb_memtoreg, wb_wdst, muldiv_start, muldiv_busy
   );
endinterface

// File: rtl/pipe_ctrl_ctrl_decode.sv
// ctrl_decode: combinational opcode/funct decode into the ID control bundle and resolved destination.
// Muldiv functs become no-write bubbles unless PIPE_CTRL_MULDIV_EN is defined.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(parameter int REG_AW = 5) (
   input  logic              id_valid,
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   output ctrl_t             ctl,
   output logic [REG_AW-1:0] wdst
);
   ctrl_t             c;
   regdst_e           regdst;
   logic [REG_AW-1:0] w;
   always_comb begin
      c = '0;
      regdst = RD_RT;
      case (opcode)
         OP_RTYPE: begin
            c.valid = 1'b1;
            c.uses_rt = 1'b1;
            c.regwrite = 1'b1;
            c.alusrc1 = is_shift(funct);
            regdst = RD_RD;
            if (funct == F_JR || funct == F_JALR) begin
               c.pcsrc = PC_JR;
               c.regwrite = funct == F_JALR;
               c.memtoreg = MR_PC4;
            end
            if (is_muldiv(funct)) begin
               c.regwrite = 1'b0;
`ifdef PIPE_CTRL_MULDIV_EN
               c.muldiv = 1'b1;
`else
               c.valid = 1'b0;
`endif
            end
`ifdef PIPE_CTRL_MULDIV_EN
            c.mfhilo = funct == F_MFHI || funct == F_MFLO;
`endif
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            c.valid = 1'b1;
            c.alusrc2 = 1'b1;
            c.regwrite = 1'b1;
         end
         OP_LW: begin
            c.valid = 1'b1;
            c.alusrc2 = 1'b1;
            c.memread = 1'b1;
            c.regwrite = 1'b1;
            c.memtoreg = MR_MEM;
         end
         OP_SW: begin
            c.valid = 1'b1;
            c.alusrc2 = 1'b1;
            c.memwrite = 1'b1;
            c.uses_rt = 1'b1;
         end
         OP_BEQ: begin
            c.valid = 1'b1;
            c.branch = 1'b1;
            c.uses_rt = 1'b1;
         end
         OP_J: begin
            c.valid = 1'b1;
            c.pcsrc = PC_J;
         end
         OP_JAL: begin
            c.valid = 1'b1;
            c.pcsrc = PC_J;
            c.regwrite = 1'b1;
            c.memtoreg = MR_PC4;
            regdst = RD_31;
         end
         default: ;
      endcase
      c.luop = opcode == OP_LUI;
      c.aluop = {opcode[0], opcode == OP_RTYPE ? ALU_R : opcode == OP_BEQ ? ALU_BEQ :
                 opcode == OP_ANDI ? ALU_AND : (opcode == OP_SLTI || opcode == OP_SLTIU) ? ALU_SLT : ALU_ADD};
      w = regdst == RD_RD ? rd : regdst == RD_31 ? REG_AW'(31) : rt;
      c.regwrite = c.regwrite && w != '0;
      ctl = id_valid ? c : '0;
      wdst = id_valid ? w : '0;
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage MIPS control pipeline with load-use, jr and branch hazard handling.
// Define PIPE_CTRL_MULDIV_EN to add the multi-cycle multiply/divide interlock.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(parameter int REG_AW = 5, parameter int MULDIV_LAT = 32) (
   input logic        clk,
   input logic        reset,
   pipe_ctrl_if.slave p
);
   ctrl_t             dec;
   logic [REG_AW-1:0] dec_wdst, ex_wdst_d, ex_wdst_q, mem_wdst_d, mem_wdst_q, wb_wdst_d, wb_wdst_q;
   ex_t               ex_d, ex_q;
   mem_t              mem_d, mem_q;
   wb_t               wb_d, wb_q;
   logic              load_use, jr_stall, md_stall, stall, flush_br, bubble;
   ctrl_decode #(.REG_AW(REG_AW)) u_dec (
      .id_valid(p.id_valid), .opcode(p.id_opcode), .funct(p.id_funct),
      .rt(p.id_rt), .rd(p.id_rd), .ctl(dec), .wdst(dec_wdst)
   );
`ifdef PIPE_CTRL_MULDIV_EN
   localparam int CW = $clog2(MULDIV_LAT + 1);
   logic [CW-1:0] cnt_d, cnt_q;
   assign md_stall = cnt_q != '0 && (dec.muldiv || dec.mfhilo);
   always_comb cnt_d = ex_d.muldiv ? CW'(MULDIV_LAT) : cnt_q - CW'(cnt_q != '0);
   always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
   assign p.muldiv_start = ex_q.muldiv;
   assign p.muldiv_busy = cnt_q != '0;
`else
   assign md_stall = 1'b0;
   assign p.muldiv_start = 1'b0;
   assign p.muldiv_busy = 1'b0;
`endif
   always_comb begin
      flush_br = ex_q.branch && p.branch_taken_ex;
      load_use = dec.valid && ex_q.memread && ex_wdst_q != '0 &&
                 (ex_wdst_q == p.id_rs || (dec.uses_rt && ex_wdst_q == p.id_rt));
      jr_stall = dec.pcsrc == PC_JR && ((ex_q.regwrite && ex_wdst_q == p.id_rs) ||
                                        (mem_q.memread && mem_wdst_q == p.id_rs));
      stall = load_use || jr_stall || md_stall;
      bubble = stall || flush_br;
   end
   always_comb begin
      ex_d = '0;
      ex_d.valid = dec.valid;
      ex_d.alusrc1 = dec.alusrc1;
      ex_d.alusrc2 = dec.alusrc2;
      ex_d.branch = dec.branch;
      ex_d.aluop = dec.aluop;
      ex_d.memread = dec.memread;
      ex_d.memwrite = dec.memwrite;
      ex_d.regwrite = dec.regwrite;
      ex_d.memtoreg = dec.memtoreg;
`ifdef PIPE_CTRL_MULDIV_EN
      ex_d.muldiv = dec.muldiv;
`endif
      if (bubble) ex_d = '0;
      ex_wdst_d = bubble ? '0 : dec_wdst;
      mem_d = '{memread: ex_q.memread, memwrite: ex_q.memwrite, regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg};
      mem_wdst_d = ex_wdst_q;
      wb_d = '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg};
      wb_wdst_d = mem_wdst_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_q <= '0;
         ex_wdst_q <= '0;
         mem_q <= '0;
         mem_wdst_q <= '0;
         wb_q <= '0;
         wb_wdst_q <= '0;
      end else begin
         ex_q <= ex_d;
         ex_wdst_q <= ex_wdst_d;
         mem_q <= mem_d;
         mem_wdst_q <= mem_wdst_d;
         wb_q <= wb_d;
         wb_wdst_q <= wb_wdst_d;
      end
   end
   // a taken branch squashes whatever ID holds, so it wins over any stall
   assign p.pc_write = flush_br || !stall;
   assign p.ifid_write = flush_br || !stall;
   assign p.flush_ifid = flush_br || (dec.pcsrc != PC_SEQ && !stall);
   assign p.id_pcsrc = flush_br ? PC_SEQ : dec.pcsrc;
   assign p.id_extop = 1'b1;
   assign p.id_luop = dec.luop;
   assign p.ex_valid = ex_q.valid;
   assign p.ex_alusrc1 = ex_q.alusrc1;
   assign p.ex_alusrc2 = ex_q.alusrc2;
   assign p.ex_branch = ex_q.branch;
   assign p.ex_aluop = ex_q.aluop;
   assign p.ex_memread = ex_q.memread;
   assign p.ex_memwrite = ex_q.memwrite;
   assign p.ex_regwrite = ex_q.regwrite;
   assign p.ex_wdst = ex_wdst_q;
   assign p.mem_memread = mem_q.memread;
   assign p.mem_memwrite = mem_q.memwrite;
   assign p.mem_regwrite = mem_q.regwrite;
   assign p.mem_memtoreg = mem_q.memtoreg;
   assign p.mem_wdst = mem_wdst_q;
   assign p.wb_regwrite = wb_q.regwrite;
   assign p.wb_memtoreg = wb_q.memtoreg;
   assign p.wb_wdst = wb_wdst_q;
endmodule
